// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter and issue sequencer that shares one ALU among
// NREQ requesters. An accepted op sits one cycle in the issue register and
// drives the ALU bus. Its result comes back with a one-cycle done pulse.
// A requester can hold a lock so that a carry chain runs without
// interleaving from the other requesters.
// Optional build macro: ALU_ARB_LOCK_TIMEOUT_EN adds an idle timeout on the
// lock (LOCK_MAX cycles) and drives lock_err.
module alu_arb #(
  parameter int unsigned NREQ     = 2,
  parameter logic [7:0]  NOP_OP   = 8'h00,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*8-1:0]  req_op,
  input  logic [NREQ*2-1:0]  req_width,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  input  logic [NREQ-1:0]    req_immsel,
  input  logic [NREQ-1:0]    req_setflags,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [63:0]        rsp_data,
  output logic               rsp_zero,
  output logic               rsp_carry,
  output logic               lock_err,
  output logic [7:0]         alu_aluop,
  output logic [1:0]         alu_width,
  output logic [63:0]        alu_rdaout,
  output logic [63:0]        alu_rdbout,
  output logic [63:0]        alu_imm,
  output logic               alu_immload,
  output logic               alu_aluload,
  input  logic [63:0]        alu_aluout,
  input  logic               alu_zero,
  input  logic               alu_carry
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  lock_state_e   state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q;
  logic [NREQ-1:0] elig;
  logic [IW-1:0] cand;
  logic [IW-1:0] gidx;
  logic          gvalid;
  logic          owner_gnt;
  logic          timeout;

  logic          iss_valid_q;
  logic [IW-1:0] iss_idx_q;
  logic [7:0]    iss_op_q;
  logic [1:0]    iss_width_q;
  logic [63:0]   iss_a_q;
  logic [63:0]   iss_b_q;
  logic          iss_immsel_q;
  logic          iss_setflags_q;

  logic          done_valid_q;
  logic [IW-1:0] done_idx_q;

  // Lock state register (state and owning requester)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Lock next-state: both transitions use the pre-edge locked/owner state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      UNLOCKED: begin
        if (gvalid && lock[gidx]) begin
          state_d = LOCKED;
          owner_d = gidx;
        end
      end
      LOCKED: begin
        if ((owner_gnt && !lock[owner_q]) || timeout) begin
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Lock outputs: eligibility mask seen by the arbiter
  always_comb begin
    elig = req;
    if (state_q == LOCKED) begin
      elig = '0;
      elig[owner_q] = req[owner_q];
    end
  end

  // Round-robin pick: first eligible index at or after rr_q, wrapping
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_q) + k) % NREQ);
      if (!gvalid && !reset && elig[cand]) begin
        gvalid = 1'b1;
        gidx   = cand;
      end
    end
  end

  assign owner_gnt = gvalid && (state_q == LOCKED) && (gidx == owner_q);

  // One-hot grant and done decode
  always_comb begin
    gnt  = '0;
    done = '0;
    if (gvalid) gnt[gidx] = 1'b1;
    if (done_valid_q) done[done_idx_q] = 1'b1;
  end

  // Issue register, rr pointer and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q           <= '0;
      iss_valid_q    <= 1'b0;
      iss_idx_q      <= '0;
      iss_op_q       <= NOP_OP;
      iss_width_q    <= '0;
      iss_a_q        <= '0;
      iss_b_q        <= '0;
      iss_immsel_q   <= 1'b0;
      iss_setflags_q <= 1'b0;
      done_valid_q   <= 1'b0;
      done_idx_q     <= '0;
      rsp_data       <= '0;
    end else begin
      iss_valid_q <= gvalid;
      if (gvalid) begin
        rr_q           <= IW'((32'(gidx) + 32'd1) % NREQ);
        iss_idx_q      <= gidx;
        iss_op_q       <= req_op[8*gidx +: 8];
        iss_width_q    <= req_width[2*gidx +: 2];
        iss_a_q        <= req_a[64*gidx +: 64];
        iss_b_q        <= req_b[64*gidx +: 64];
        iss_immsel_q   <= req_immsel[gidx];
        iss_setflags_q <= req_setflags[gidx];
      end
      done_valid_q <= iss_valid_q;
      done_idx_q   <= iss_idx_q;
      if (iss_valid_q) rsp_data <= alu_aluout;
    end
  end

  // ALU bus: idle bus is NOP with all operands zero
  always_comb begin
    alu_aluop   = iss_valid_q ? iss_op_q : NOP_OP;
    alu_width   = iss_valid_q ? iss_width_q : 2'b00;
    alu_rdaout  = iss_valid_q ? iss_a_q : '0;
    alu_rdbout  = (iss_valid_q && !iss_immsel_q) ? iss_b_q : '0;
    alu_imm     = (iss_valid_q && iss_immsel_q) ? iss_b_q : '0;
    alu_immload = iss_valid_q & iss_immsel_q;
    alu_aluload = iss_valid_q & iss_setflags_q;
  end

  assign rsp_zero  = alu_zero;
  assign rsp_carry = alu_carry;

`ifdef ALU_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] idle_q;

  assign timeout = (state_q == LOCKED) && !owner_gnt && (idle_q == CW'(LOCK_MAX - 1));

  // Idle counter: runs while locked, cleared by an owner grant or unlock
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q   <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= timeout;
      if (state_q != LOCKED || owner_gnt || timeout) idle_q <= '0;
      else idle_q <= idle_q + CW'(1);
    end
  end
`else
  // Lock never expires; LOCK_MAX stays referenced so both builds share one parameter list
  assign timeout  = (LOCK_MAX == 0) && 1'b0;
  assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: bench for alu_arb with three requesters, a small flag-holding
// ALU model, and a transaction-level reference (grant order, lock ownership,
// expected results and flags) stepped once per cycle.
module tb_alu_arb;

  localparam int N = 3;
  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] ADD  = 8'h01;
  localparam logic [7:0] ADC  = 8'h02;
  localparam logic [7:0] ANDO = 8'h03;
  localparam logic [7:0] XORO = 8'h04;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    req, lock, req_immsel, req_setflags;
  logic [N*8-1:0]  req_op;
  logic [N*2-1:0]  req_width;
  logic [N*64-1:0] req_a, req_b;
  logic [N-1:0]    gnt, done;
  logic [63:0]     rsp_data;
  logic            rsp_zero, rsp_carry, lock_err;
  logic [7:0]      alu_aluop;
  logic [1:0]      alu_width;
  logic [63:0]     alu_rdaout, alu_rdbout, alu_imm, alu_aluout;
  logic            alu_immload, alu_aluload;
  logic            alu_zero = 1'b0;
  logic            alu_carry = 1'b0;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  alu_arb #(.NREQ(N), .NOP_OP(NOP), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .req_op(req_op),
    .req_width(req_width), .req_a(req_a), .req_b(req_b),
    .req_immsel(req_immsel), .req_setflags(req_setflags), .gnt(gnt),
    .done(done), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry), .lock_err(lock_err), .alu_aluop(alu_aluop),
    .alu_width(alu_width), .alu_rdaout(alu_rdaout), .alu_rdbout(alu_rdbout),
    .alu_imm(alu_imm), .alu_immload(alu_immload), .alu_aluload(alu_aluload),
    .alu_aluout(alu_aluout), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // {carry_out, result} of one ALU operation
  function automatic logic [64:0] alu_calc(input logic [7:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic cin);
    case (op)
      ADD:     return {1'b0, a} + {1'b0, b};
      ADC:     return {1'b0, a} + {1'b0, b} + {64'd0, cin};
      ANDO:    return {1'b0, a & b};
      XORO:    return {1'b0, a ^ b};
      default: return '0;
    endcase
  endfunction

  // External ALU: combinational result, flags registered on aluload
  logic [64:0] alu_r;
  assign alu_r = alu_calc(alu_aluop, alu_rdaout, alu_immload ? alu_imm : alu_rdbout, alu_carry);
  assign alu_aluout = alu_r[63:0];
  always @(posedge clk) begin
    if (alu_aluload) begin
      alu_carry <= alu_r[64];
      alu_zero  <= (alu_r[63:0] == 64'd0);
    end
  end

  typedef struct {
    bit v; int idx; logic [7:0] op; logic [1:0] w; logic [63:0] a; logic [63:0] b;
    bit imm; bit sf; logic [63:0] res; bit z; bit c;
  } ent_t;

  ent_t st1, st2;
  bit   p_v[N], p_imm[N], p_sf[N], p_lk[N];
  logic [7:0]  p_op[N];
  logic [1:0]  p_w[N];
  logic [63:0] p_a[N], p_b[N];
  int  m_rr = 0, m_owner = 0;
  bit  m_locked = 0, m_c = 0, m_z = 0;

  logic [N-1:0] obs_gnt, obs_done;
  logic [63:0]  obs_data, obs_imm, obs_rdb;
  logic [7:0]   obs_aluop;
  logic         obs_aluload, obs_immload;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] op, input logic [63:0] a,
                        input logic [63:0] b, input bit imm, input bit sf, input bit lk);
    p_v[i] = 1; p_op[i] = op; p_w[i] = 2'd3; p_a[i] = a; p_b[i] = b;
    p_imm[i] = imm; p_sf[i] = sf; p_lk[i] = lk;
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic refill(input int i);
    set_op(i, 8'($urandom_range(1, 4)), rand64(), rand64(), bit'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    p_w[i] = 2'($urandom_range(0, 3));
  endtask

  // One clock: drive, check against the reference, advance the reference
  task automatic step(input bit rst);
    int g;
    int i;
    logic [N-1:0] eg, ed;
    logic [64:0] r;
    ent_t n;
    @(negedge clk);
    reset = rst;
    for (int k = 0; k < N; k++) begin
      req[k] = p_v[k]; lock[k] = p_lk[k]; req_immsel[k] = p_imm[k]; req_setflags[k] = p_sf[k];
      req_op[8*k +: 8] = p_op[k]; req_width[2*k +: 2] = p_w[k];
      req_a[64*k +: 64] = p_a[k]; req_b[64*k +: 64] = p_b[k];
    end
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (g < 0 && p_v[i] && (!m_locked || i == m_owner)) g = i;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", gnt, eg);
    chk("aluop", alu_aluop, st1.v ? st1.op : NOP);
    chk("width", alu_width, st1.v ? st1.w : 2'd0);
    chk("rdaout", alu_rdaout, st1.v ? st1.a : 64'd0);
    chk("rdbout", alu_rdbout, (st1.v && !st1.imm) ? st1.b : 64'd0);
    chk("imm", alu_imm, (st1.v && st1.imm) ? st1.b : 64'd0);
    chk("immload", alu_immload, st1.v && st1.imm);
    chk("aluload", alu_aluload, st1.v && st1.sf);
    ed = '0;
    if (st2.v) ed[st2.idx] = 1'b1;
    chk("done", done, ed);
    if (st2.v) begin
      chk("rsp_data", rsp_data, st2.res);
      chk("rsp_zero", rsp_zero, st2.z);
      chk("rsp_carry", rsp_carry, st2.c);
    end
    chk("lock_err", lock_err, 0);
    obs_gnt = gnt; obs_done = done; obs_data = rsp_data; obs_imm = alu_imm;
    obs_rdb = alu_rdb_view(); obs_aluop = alu_aluop; obs_aluload = alu_aluload;
    obs_immload = alu_immload;

    st2 = st1;
    n = '{default: 0};
    if (g >= 0) begin
      n.v = 1; n.idx = g; n.op = p_op[g]; n.w = p_w[g]; n.a = p_a[g]; n.b = p_b[g];
      n.imm = p_imm[g]; n.sf = p_sf[g];
      r = alu_calc(p_op[g], p_a[g], p_b[g], m_c);
      n.res = r[63:0];
      if (p_sf[g]) begin
        m_c = r[64];
        m_z = (r[63:0] == 64'd0);
      end
      n.c = m_c; n.z = m_z;
      if (!m_locked && p_lk[g]) begin
        m_locked = 1; m_owner = g;
      end else if (m_locked && g == m_owner && !p_lk[g]) begin
        m_locked = 0;
      end
      m_rr = (g + 1) % N;
      p_v[g] = 0;
    end
    st1 = n;
    if (rst) begin
      st1.v = 0; st2.v = 0; m_rr = 0; m_locked = 0; m_owner = 0;
    end
    @(posedge clk);
  endtask

  function automatic logic [63:0] alu_rdb_view();
    return alu_rdbout;
  endfunction

  initial begin
    reset = 1'b1;
    req = '0; lock = '0; req_immsel = '0; req_setflags = '0;
    req_op = '0; req_width = '0; req_a = '0; req_b = '0;
    st1 = '{default: 0}; st2 = '{default: 0};
    for (int k = 0; k < N; k++) begin
      p_v[k] = 0; p_imm[k] = 0; p_sf[k] = 0; p_lk[k] = 0;
      p_op[k] = NOP; p_w[k] = 0; p_a[k] = 0; p_b[k] = 0;
    end
    step(1); step(1);
    #1;
    chk("reset rsp_data", rsp_data, 64'd0);
    chk("reset done", done, 0);
    chk("reset aluop", alu_aluop, NOP);

    // back-to-back: both requesters re-present immediately after their grant
    set_op(0, ADD, 64'd1, 64'd2, 0, 0, 0);
    set_op(1, ADD, 64'd3, 64'd4, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0);
      if (k < 4) chk("b2b gnt", obs_gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
      if (k >= 2) chk("b2b done", obs_done, (k % 2 == 0) ? 3'b001 : 3'b010);
      if (k < 2) set_op(k % 2, ADD, 64'(k + 10), 64'd1, 0, 0, 0);
    end

    // single add 5+7 with flag update
    set_op(0, ADD, 64'd5, 64'd7, 0, 1, 0);
    step(0); chk("add gnt", obs_gnt, 3'b001);
    step(0); chk("add aluop", obs_aluop, ADD); chk("add aluload", obs_aluload, 1'b1);
    step(0); chk("add done", obs_done, 3'b001); chk("add data", obs_data, 64'd12);

    // locked carry chain: requester 1 stalls until the adc closes the lock
    set_op(0, ADD, '1, 64'd1, 0, 1, 1);
    step(0); chk("lock gnt", obs_gnt, 3'b001);
    set_op(1, XORO, 64'd3, 64'd5, 0, 0, 0);
    step(0); chk("lock stall", obs_gnt, 3'b000);
    step(0); chk("lock stall2", obs_gnt, 3'b000);
    set_op(0, ADC, 64'd0, 64'd0, 0, 1, 0);
    step(0); chk("adc gnt", obs_gnt, 3'b001);
    step(0); chk("after unlock gnt", obs_gnt, 3'b010);
    step(0); chk("adc done", obs_done, 3'b001); chk("adc data", obs_data, 64'd1);

    // immediate operand routing, then idle bus
    step(0);
    set_op(0, ADD, 64'd3, 64'h10, 1, 0, 0);
    step(0);
    step(0); chk("imm bus", obs_imm, 64'h10); chk("imm rdb", obs_rdb, 64'd0);
    chk("imm immload", obs_immload, 1'b1);
    step(0); chk("idle aluop", obs_aluop, NOP); chk("idle aluload", obs_aluload, 1'b0);

    // reset with a locking op in flight
    set_op(0, ADD, 64'd9, 64'd9, 0, 1, 1);
    step(0);
    set_op(1, ANDO, 64'hF0, 64'h3C, 0, 1, 0);
    step(1);
    step(0); chk("rst done", obs_done, 3'b000); chk("rst data", obs_data, 64'd0);
    chk("rst unlock gnt", obs_gnt, 3'b010);

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++)
        if (!p_v[k] && $urandom_range(0, 3) != 0) refill(k);
    end
    for (int k = 0; k < N; k++) p_v[k] = 0;
    for (int c = 0; c < 4; c++) step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
